// File: rtl/gnn_ctrl_pkg.sv
// Shared types and helpers for the GNN control sequencers.
// Holds the scheduler state encoding, counter width helper and default watchdog depth.
package gnn_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAN = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 64;

    // Bits needed to hold values 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Loadable down-counter that flags expiry while enabled and sitting at zero.
// Shared by the graph controllers to bound waits on downstream engines.
module sched_watchdog #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/matvec_sched.sv
// Sequencer feeding one graph node's neighbour vectors through a single matvec engine.
// Clears the engine per group, issues one compute per vector and hands the final sum downstream.
module matvec_sched
    import gnn_ctrl_pkg::*;
#(
    parameter int IN_C    = 34,
    parameter int OUT_C   = 32,
    parameter int F_WIDTH = 8,
    parameter int B_WIDTH = 32,
    parameter int MAX_VEC = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int CNT_W  = count_width(MAX_VEC),
    localparam int TO_W   = count_width(TIMEOUT)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_last,
    input  logic [IN_C*F_WIDTH-1:0]    s_feat,
    output logic                       mv_clean,
    output logic                       mv_calc_en,
    output logic [IN_C*F_WIDTH-1:0]    mv_feature,
    input  logic [OUT_C*B_WIDTH-1:0]   mv_accum,
    input  logic                       mv_accum_valid,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_C*B_WIDTH-1:0]   m_data,
    output logic [CNT_W-1:0]           m_count,
    output logic                       busy,
    output logic                       err_timeout
);

    sched_state_t     state, state_nxt;
    logic             armed, armed_nxt;
    logic             last_r;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_sat;
    logic             take_vec;
    logic             capture;
    logic             ready_c;
    logic             wd_load;
    logic             wd_en;
    logic             wd_expire;

    assign cnt_sat = (cnt == CNT_W'(MAX_VEC)) ? cnt : cnt + 1'b1;

    sched_watchdog #(
        .WIDTH(TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rstn    (rstn),
        .load    (wd_load),
        .load_val(TO_W'(TIMEOUT - 1)),
        .en      (wd_en),
        .expire  (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_IDLE;
            armed      <= 1'b0;
            last_r     <= 1'b0;
            cnt        <= '0;
            mv_feature <= '0;
            m_data     <= '0;
            m_count    <= '0;
        end else begin
            state <= state_nxt;
            armed <= armed_nxt;
            if (take_vec) begin
                mv_feature <= s_feat;
                last_r     <= s_last;
                cnt        <= cnt_nxt;
            end
            if (capture) begin
                m_data  <= mv_accum;
                m_count <= cnt;
            end
        end
    end

    // Armed means the previous result is back and we only wait for the next vector,
    // so the watchdog is paused and engine valids are ignored.
    always_comb begin
        state_nxt   = state;
        armed_nxt   = armed;
        cnt_nxt     = cnt;
        take_vec    = 1'b0;
        capture     = 1'b0;
        ready_c     = 1'b0;
        wd_load     = 1'b0;
        wd_en       = 1'b0;
        err_timeout = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready_c   = 1'b1;
                armed_nxt = 1'b0;
                if (s_valid) begin
                    take_vec  = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = S_CLEAN;
                end
            end
            S_CLEAN: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                wd_load   = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (armed) begin
                    ready_c = 1'b1;
                    if (s_valid) begin
                        take_vec  = 1'b1;
                        cnt_nxt   = cnt_sat;
                        armed_nxt = 1'b0;
                        state_nxt = S_ISSUE;
                    end
                end else if (mv_accum_valid) begin
                    if (last_r) begin
                        capture   = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        ready_c = 1'b1;
                        if (s_valid) begin
                            take_vec  = 1'b1;
                            cnt_nxt   = cnt_sat;
                            state_nxt = S_ISSUE;
                        end else begin
                            armed_nxt = 1'b1;
                        end
                    end
                end else begin
                    wd_en = 1'b1;
                    if (wd_expire) begin
                        err_timeout = 1'b1;
                        state_nxt   = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (m_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign s_ready    = ready_c & rstn;
    assign mv_clean   = (state == S_CLEAN);
    assign mv_calc_en = (state == S_ISSUE);
    assign m_valid    = (state == S_OUT);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_matvec_sched.sv
// Directed-random bench for matvec_sched with a behavioural matvec engine model.
// Expected sums are rebuilt from the list of vectors offered in each group.
module tb_matvec_sched;

    localparam int IN_C    = 34;
    localparam int OUT_C   = 32;
    localparam int F_WIDTH = 8;
    localparam int B_WIDTH = 32;
    localparam int MAX_VEC = 16;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 5;
    localparam int FW      = IN_C * F_WIDTH;
    localparam int AW      = OUT_C * B_WIDTH;

    logic             clk;
    logic             rstn;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;
    logic [FW-1:0]    s_feat;
    logic             mv_clean;
    logic             mv_calc_en;
    logic [FW-1:0]    mv_feature;
    logic [AW-1:0]    mv_accum;
    logic             mv_accum_valid;
    logic             m_valid;
    logic             m_ready;
    logic [AW-1:0]    m_data;
    logic [CNT_W-1:0] m_count;
    logic             busy;
    logic             err_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_clean = 0, n_calc = 0, n_err = 0, n_mval = 0;
    int clean_cyc = 0, calc_cyc = 0, err_cyc = 0, mval_cyc = 0;
    logic mval_prev = 1'b0;

    int  lat       = 4;
    bit  respond   = 1'b1;
    bit  spurious  = 1'b0;
    int  pend      = 0;
    logic [FW-1:0] pfeat;
    logic [31:0]   macc [OUT_C];
    int  exp_sum [OUT_C];

    matvec_sched #(
        .IN_C   (IN_C),
        .OUT_C  (OUT_C),
        .F_WIDTH(F_WIDTH),
        .B_WIDTH(B_WIDTH),
        .MAX_VEC(MAX_VEC),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_last        (s_last),
        .s_feat        (s_feat),
        .mv_clean      (mv_clean),
        .mv_calc_en    (mv_calc_en),
        .mv_feature    (mv_feature),
        .mv_accum      (mv_accum),
        .mv_accum_valid(mv_accum_valid),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_count       (m_count),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Matvec engine model: clean zeroes the sums, each compute lands lat cycles later
    // adding byte j of the feature into lane j; the bus carries noise when not valid.
    initial begin
        mv_accum_valid = 1'b0;
        mv_accum       = '0;
        pfeat          = '0;
        for (int j = 0; j < OUT_C; j++) macc[j] = '0;
        forever begin
            @(negedge clk);
            mv_accum_valid = 1'b0;
            for (int j = 0; j < OUT_C; j++) mv_accum[j*32 +: 32] = $urandom();
            if (!rstn) begin
                pend = 0;
                for (int j = 0; j < OUT_C; j++) macc[j] = '0;
            end else begin
                if (mv_clean) begin
                    for (int j = 0; j < OUT_C; j++) macc[j] = '0;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        for (int j = 0; j < OUT_C; j++) begin
                            macc[j] = macc[j] + {24'd0, pfeat[j*8 +: 8]};
                            mv_accum[j*32 +: 32] = macc[j];
                        end
                        mv_accum_valid = 1'b1;
                    end
                end
                if (mv_calc_en && respond) begin
                    pend  = lat;
                    pfeat = mv_feature;
                end
                if (spurious) begin
                    mv_accum_valid = 1'b1;
                    spurious       = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mv_clean)    begin n_clean++; clean_cyc = cyc; end
            if (mv_calc_en)  begin n_calc++;  calc_cyc  = cyc; end
            if (err_timeout) begin n_err++;   err_cyc   = cyc; end
            if (m_valid && !mval_prev) begin n_mval++; mval_cyc = cyc; end
            mval_prev = m_valid;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [FW-1:0] rand_feat();
        logic [FW-1:0] f;
        for (int b = 0; b < IN_C; b++) f[b*8 +: 8] = 8'($urandom());
        return f;
    endfunction

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_s_ready"},  64'(s_ready), 64'd0);
        checkOutput({tag, "_clean"},    64'(mv_clean), 64'd0);
        checkOutput({tag, "_calc"},     64'(mv_calc_en), 64'd0);
        checkOutput({tag, "_m_valid"},  64'(m_valid), 64'd0);
        checkOutput({tag, "_m_count"},  64'(m_count), 64'd0);
        checkOutput({tag, "_busy"},     64'(busy), 64'd0);
        checkOutput({tag, "_err"},      64'(err_timeout), 64'd0);
        checkOutput({tag, "_feature"},  64'(|mv_feature), 64'd0);
        checkOutput({tag, "_m_data"},   64'(|m_data), 64'd0);
    endtask

    task automatic send_vec(input logic [FW-1:0] f, input logic last, output int hs);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_feat  = f;
        s_last  = last;
        while (!s_ready && guard < 300) begin
            step();
            guard++;
        end
        checkOutput("handshake_in_time", 64'(guard < 300), 64'd1);
        hs = cyc;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_feat  = rand_feat();
    endtask

    task automatic wait_result(input int n, input int hold);
        int guard;
        int c0;
        int exp_cnt;
        guard   = 0;
        exp_cnt = (n > MAX_VEC) ? MAX_VEC : n;
        while (!m_valid && guard < 400) begin
            step();
            guard++;
        end
        checkOutput("m_valid_seen", 64'(m_valid), 64'd1);
        checkOutput("m_count", 64'(m_count), 64'(exp_cnt));
        for (int j = 0; j < OUT_C; j++)
            checkOutput($sformatf("lane%0d", j), 64'(m_data[j*32 +: 32]), 64'(32'(exp_sum[j])));
        checkOutput("out_s_ready", 64'(s_ready), 64'd0);
        c0 = n_calc;
        for (int i = 0; i < hold; i++) begin
            step();
            checkOutput("hold_m_valid", 64'(m_valid), 64'd1);
            checkOutput("hold_s_ready", 64'(s_ready), 64'd0);
            checkOutput("hold_m_count", 64'(m_count), 64'(exp_cnt));
            checkOutput("hold_lane0", 64'(m_data[31:0]), 64'(32'(exp_sum[0])));
            checkOutput("hold_lane31", 64'(m_data[AW-1 -: 32]), 64'(32'(exp_sum[OUT_C-1])));
        end
        checkOutput("hold_no_calc", 64'(n_calc - c0), 64'd0);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checkOutput("post_m_valid", 64'(m_valid), 64'd0);
        checkOutput("post_busy", 64'(busy), 64'd0);
    endtask

    task automatic applyStimulus(input int n, input int lat_v, input int hold,
                                 input logic [7:0] fixed, output int hs0);
        logic [FW-1:0] f;
        int hs;
        lat = lat_v;
        hs0 = 0;
        for (int j = 0; j < OUT_C; j++) exp_sum[j] = 0;
        for (int i = 0; i < n; i++) begin
            if (fixed != 8'd0) begin
                for (int b = 0; b < IN_C; b++) f[b*8 +: 8] = fixed;
            end else begin
                f = rand_feat();
            end
            for (int j = 0; j < OUT_C; j++) exp_sum[j] += int'(f[j*8 +: 8]);
            if (i > 0) repeat ($urandom_range(0, 3)) step();
            send_vec(f, (i == n - 1), hs);
            if (i == 0) hs0 = hs;
        end
        wait_result(n, hold);
    endtask

    initial begin
        int hs;
        int c_clean, c_calc, c_err, c_mval;

        rstn    = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_feat  = '0;
        m_ready = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");
        rstn = 1'b1;
        s_feat = rand_feat();
        step();
        checkOutput("idle_s_ready", 64'(s_ready), 64'd1);

        $display("[TB] single vector group, latency 4");
        applyStimulus(1, 4, 0, 8'h11, hs);
        checkOutput("t1_clean_cyc", 64'(clean_cyc), 64'(hs + 1));
        checkOutput("t1_calc_cyc",  64'(calc_cyc),  64'(hs + 2));
        checkOutput("t1_mval_cyc",  64'(mval_cyc),  64'(hs + 7));

        $display("[TB] three vector group");
        c_clean = n_clean;
        c_calc  = n_calc;
        applyStimulus(3, int'($urandom_range(1, 6)), 0, 8'd0, hs);
        checkOutput("t2_cleans", 64'(n_clean - c_clean), 64'd1);
        checkOutput("t2_calcs",  64'(n_calc - c_calc),   64'd3);

        $display("[TB] downstream backpressure");
        applyStimulus(2, 3, 10, 8'd0, hs);

        $display("[TB] watchdog abort");
        respond = 1'b0;
        c_err   = n_err;
        c_mval  = n_mval;
        send_vec(rand_feat(), 1'b1, hs);
        for (int g = 0; g < 200 && n_err == c_err; g++) step();
        checkOutput("t4_err_seen", 64'(n_err - c_err), 64'd1);
        checkOutput("t4_err_delay", 64'(err_cyc - calc_cyc), 64'(TIMEOUT));
        repeat (3) step();
        checkOutput("t4_err_pulses", 64'(n_err - c_err), 64'd1);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        checkOutput("t4_no_mvalid", 64'(n_mval - c_mval), 64'd0);
        respond = 1'b1;
        c_clean = n_clean;
        applyStimulus(2, 2, 0, 8'd0, hs);
        checkOutput("t4_next_clean", 64'(n_clean - c_clean), 64'd1);

        $display("[TB] saturating twenty vector group");
        c_clean = n_clean;
        c_calc  = n_calc;
        applyStimulus(20, int'($urandom_range(1, 4)), 0, 8'd0, hs);
        checkOutput("t5_cleans", 64'(n_clean - c_clean), 64'd1);
        checkOutput("t5_calcs",  64'(n_calc - c_calc),   64'd20);
        c_mval   = n_mval;
        spurious = 1'b1;
        repeat (4) step();
        checkOutput("t5_spur_mvalid", 64'(n_mval - c_mval), 64'd0);
        checkOutput("t5_spur_busy", 64'(busy), 64'd0);
        checkOutput("t5_spur_ready", 64'(s_ready), 64'd1);

        $display("[TB] reset while waiting on the engine");
        lat = 6;
        send_vec(rand_feat(), 1'b0, hs);
        step();
        step();
        checkOutput("t6_busy_wait", 64'(busy), 64'd1);
        rstn = 1'b0;
        step();
        check_reset_outputs("t6_rst");
        rstn = 1'b1;
        step();
        c_clean = n_clean;
        applyStimulus(3, 3, 1, 8'd0, hs);
        checkOutput("t6_clean_after", 64'(n_clean - c_clean), 64'd1);

        $display("[TB] random groups");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)),
                          int'($urandom_range(0, 3)), 8'd0, hs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matvec_sched.md
Name: matvec_sched

Overview:
- Sequencer that drives a single matvec engine for one graph node at a time.
- Accepts a stream of neighbour feature vectors grouped by a last flag, and clears the engine's accumulators before each group.
- Issues one calc_en per vector and waits for each accum_out_valid before issuing the next.
- Registers the final accumulated vector and presents it downstream on a valid/ready handshake; sits between the event/graph front-end and the matvec datapath.

Parameters:
- IN_C, 34, input channels per feature vector
- OUT_C, 32, output channels
- F_WIDTH, 8, bits per input feature
- B_WIDTH, 32, bits per accumulator lane
- MAX_VEC, 16, maximum vectors per group; the counter saturates here
- TIMEOUT, 64, cycles to wait for accum_out_valid before aborting
- Derived: CNT_W = $clog2(MAX_VEC+1), TO_W = $clog2(TIMEOUT+1)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- s_valid  in  1  input vector valid
- s_ready  out  1  input vector accepted when s_valid&s_ready
- s_last  in  1  marks last vector of a node group
- s_feat  in  IN_C*F_WIDTH  packed feature vector
- mv_clean  out  1  accumulator clear pulse to matvec
- mv_calc_en  out  1  single-cycle compute strobe to matvec
- mv_feature  out  IN_C*F_WIDTH  registered feature vector to matvec
- mv_accum  in  OUT_C*B_WIDTH  matvec accum_out_pack
- mv_accum_valid  in  1  matvec accum_out_valid
- m_valid  out  1  result valid
- m_ready  in  1  downstream ready
- m_data  out  OUT_C*B_WIDTH  registered result
- m_count  out  CNT_W  vectors aggregated into m_data
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset: one clock, clk; reset is synchronous and active-low on rstn.
  - While rstn=0 at a rising edge: state=IDLE, every output except m_data = 0, counters = 0.
  - m_data and mv_feature hold 0.
  - Reset mid-operation abandons the group immediately; no clean is issued until the next group.
- FSM states: IDLE, CLEAN, ISSUE, WAIT, OUT.
  - IDLE: s_ready=1.
    - On handshake: latch s_feat into mv_feature, latch s_last into last_r, cnt=1 -> CLEAN.
  - CLEAN: mv_clean=1 for exactly one cycle -> ISSUE.
  - ISSUE: mv_calc_en=1 for exactly one cycle, timer=0 -> WAIT.
  - WAIT: s_ready=0 until mv_accum_valid.
    - On mv_accum_valid with last_r=1: capture mv_accum into m_data and cnt into m_count, m_valid=1 -> OUT.
    - On mv_accum_valid with last_r=0: s_ready=1 in that same cycle.
      - If a handshake occurs: latch the new vector, cnt=min(cnt+1,MAX_VEC) -> ISSUE.
      - Otherwise go to a sub-condition of WAIT with an "armed" flag and stay until handshake; the timer is not running while armed.
    - If timer reaches TIMEOUT-1 without mv_accum_valid: err_timeout=1, m_valid stays 0 -> IDLE. The next group's CLEAN discards the partial sums.
  - OUT: m_valid held with m_data/m_count stable until m_ready.
    - On m_valid&m_ready -> IDLE, m_valid=0 next cycle.
    - s_ready=0 in OUT; no bypass.
- Latency:
  - First vector handshake to mv_calc_en: 2 cycles (CLEAN, then ISSUE).
  - mv_accum_valid of the last vector to m_valid: 1 cycle.
  - A single-vector group therefore takes 3 + matvec latency cycles.
- Boundary conditions:
  - mv_accum_valid outside WAIT is ignored.
  - mv_accum_valid in the same cycle as a timeout: valid wins, no error.
  - cnt saturates at MAX_VEC; further vectors are still processed.
  - s_last on the first vector gives a one-vector group.
  - s_feat is not sampled without a handshake.
- Arithmetic: no arithmetic on data; m_data is a bit-exact copy of mv_accum.

Decomposition:
- Shared package gnn_ctrl_pkg: FSM state enum (sched_state_t), width helper functions, default TIMEOUT constant.
- One natural sub-module, sched_watchdog: loadable down-counter with expire pulse, reused by the other controllers.
- Instantiate alongside matvec in a top that wires mv_* to clean/calc_en/feature_in_pack/accum_out_pack/accum_out_valid.

Test Plan:
- Reset then a single vector with s_last=1, matvec model of latency 4 returning 0x11 per lane -> mv_clean at cycle+1, mv_calc_en at +2, m_valid at +7, m_data lanes=0x11, m_count=1.
- 3-vector group with m_ready held 1 -> exactly one mv_clean, three mv_calc_en each following the prior accum_valid, m_count=3, data equals the model's final accumulation.
- m_ready held 0 for 10 cycles during OUT -> m_valid and m_data stable, s_ready=0, no calc_en issued; release -> IDLE next cycle.
- Matvec model never asserts valid -> err_timeout pulses exactly TIMEOUT cycles after calc_en, busy drops, m_valid never asserted; next group issues mv_clean.
- 20-vector group with MAX_VEC=16 -> m_count=16, 20 calc_en pulses; spurious mv_accum_valid in IDLE produces no output.
- rstn=0 asserted in WAIT -> all outputs 0 next edge; a subsequent clean group completes correctly.
